multq_requester: RTL

- Initiator side of the productQ handshake (determine_multQ / done_multQ / valid_P).
- Accepts gate jobs from the tableau update sequencer, one at a time, and drives gate type and basis index toward the productQ FSM.
- Pulses determine_multQ once per job, waits for done_multQ, captures the Q/Q2 phase results, then releases the responder with valid_P.
- Delivers the captured result downstream on a valid/ready interface.

---
 rtl/multq_requester_pkg.sv | 31 +++
 rtl/multq_wdog.sv | 29 ++
 rtl/multq_requester.sv | 127 ++++++++++++
 3 files changed

// File: rtl/multq_requester_pkg.sv
`timescale 1ns/1ps
// Shared constants and types for the productQ requester.
// Optional watchdog is enabled with MULTQ_WDOG_EN (see multq_requester).
package multq_requester_pkg;

    localparam logic [1:0] GATE_CNOT_H = 2'd0;
    localparam logic [1:0] GATE_PHASE  = 2'd1;
    localparam logic [1:0] GATE_X      = 2'd2;
    localparam logic [1:0] GATE_Z      = 2'd3;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_ISSUE     = 3'd1;
    localparam logic [2:0] ST_WAIT_DONE = 3'd2;
    localparam logic [2:0] ST_RELEASE   = 3'd3;
    localparam logic [2:0] ST_DRAIN     = 3'd4;
    localparam logic [2:0] ST_OUT       = 3'd5;

    typedef struct packed {
        logic [1:0] phase;
        logic [1:0] phase2;
        logic [1:0] gate_type;
        logic       err;
    } res_t;

    // Only two-index gates carry a meaningful Q2 phase.
    function automatic logic [1:0] mask_phase2(input logic [1:0] gate_type,
                                               input logic [1:0] phase2);
        return (gate_type == GATE_CNOT_H) ? phase2 : 2'd0;
    endfunction

endpackage

// File: rtl/multq_wdog.sv
`timescale 1ns/1ps
// Wait-for-done watchdog: 16-bit counter cleared before WAIT_DONE, counting while in it.
// Instantiated by multq_requester only when MULTQ_WDOG_EN is defined.
module multq_wdog #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    input  logic done,
    output logic expired
);

    logic [15:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 16'd0;
        end else if (clear) begin
            count <= 16'd0;
        end else if (run) begin
            count <= count + 16'd1;
        end
    end

    assign expired = run && !done && (count == 16'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/multq_requester.sv
`timescale 1ns/1ps
// Initiator side of the productQ handshake: issue one gate job, collect Q/Q2 phases, hand them on.
// Define MULTQ_WDOG_EN to add a timeout on the wait for done_multQ (res_err reports it).
module multq_requester
    import multq_requester_pkg::*;
#(
    parameter int num_qubit   = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                 clk,
    input  logic                 rst_new,
    input  logic                 job_valid,
    output logic                 job_ready,
    input  logic [1:0]           job_gate_type,
    input  logic [num_qubit-1:0] job_basis_index,
    input  logic [num_qubit-1:0] job_basis_index2,
    output logic                 determine_multQ,
    output logic [1:0]           reg_gate_type,
    output logic [num_qubit-1:0] basis_index,
    output logic [num_qubit-1:0] basis_index2,
    input  logic                 done_multQ,
    output logic                 valid_P,
    input  logic [1:0]           q_phase,
    input  logic [1:0]           q2_phase,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [1:0]           res_phase,
    output logic [1:0]           res_phase2,
    output logic [1:0]           res_gate_type,
    output logic                 res_err,
    output logic [15:0]          job_count
);

    typedef struct packed {
        logic [1:0]           gate_type;
        logic [num_qubit-1:0] basis_index;
        logic [num_qubit-1:0] basis_index2;
    } job_t;

    logic [2:0] state;
    logic [2:0] state_nx;
    logic [1:0] drain_cnt;
    logic       accept;
    logic       timeout;
    job_t       job_q;
    res_t       res_q;

    // job_ready is only ever high while in IDLE, so it alone qualifies acceptance.
    assign accept          = job_valid && job_ready;
    assign determine_multQ = (state == ST_ISSUE);
    assign res_valid       = (state == ST_OUT);

    assign reg_gate_type = job_q.gate_type;
    assign basis_index   = job_q.basis_index;
    assign basis_index2  = job_q.basis_index2;
    assign res_phase     = res_q.phase;
    assign res_phase2    = res_q.phase2;
    assign res_gate_type = res_q.gate_type;
    assign res_err       = res_q.err;

`ifdef MULTQ_WDOG_EN
    multq_wdog #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_wdog (
        .clk    (clk),
        .rst_n  (rst_new),
        .clear  (state == ST_ISSUE),
        .run    (state == ST_WAIT_DONE),
        .done   (done_multQ),
        .expired(timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:      if (accept) state_nx = ST_ISSUE;
            ST_ISSUE:     state_nx = ST_WAIT_DONE;
            ST_WAIT_DONE: if (done_multQ || timeout) state_nx = ST_RELEASE;
            ST_RELEASE:   state_nx = ST_DRAIN;
            ST_DRAIN:     if (!done_multQ) state_nx = ST_OUT;
            ST_OUT:       if (res_ready) state_nx = ST_IDLE;
            default:      state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_new) begin
        if (!rst_new) begin
            state     <= ST_IDLE;
            job_ready <= 1'b0;
            valid_P   <= 1'b0;
            drain_cnt <= 2'd0;
            job_q     <= '0;
            res_q     <= '0;
            job_count <= 16'd0;
        end else begin
            state     <= state_nx;
            job_ready <= (state_nx == ST_IDLE);
            // Release pulse lands one cycle after capture; a responder still holding
            // done is re-released every third DRAIN cycle.
            valid_P   <= (state == ST_RELEASE) ||
                         ((state == ST_DRAIN) && done_multQ && (drain_cnt == 2'd2));
            drain_cnt <= ((state == ST_DRAIN) && (drain_cnt != 2'd2)) ? drain_cnt + 2'd1 : 2'd0;
            if (accept) begin
                job_q <= '{gate_type:    job_gate_type,
                           basis_index:  job_basis_index,
                           basis_index2: job_basis_index2};
            end
            if (state == ST_WAIT_DONE) begin
                if (done_multQ) begin
                    res_q <= '{phase:     q_phase,
                               phase2:    mask_phase2(job_q.gate_type, q2_phase),
                               gate_type: job_q.gate_type,
                               err:       1'b0};
                end else if (timeout) begin
                    res_q <= '{phase: 2'd0, phase2: 2'd0, gate_type: job_q.gate_type, err: 1'b1};
                end
            end
            if (res_valid && res_ready) begin
                job_count <= job_count + 16'd1;
            end
        end
    end

endmodule
